// File: rtl/mac_ls_pkg.sv
// Shared types and sizing for the low-power block accumulator behind the dual multiply-add stage.
// No logic here; the accumulator width helper keeps the "cannot overflow" sizing in one place.
package mac_ls_pkg;

    localparam int MAC_DIN_W = 9;
    localparam int MAC_LOG2N = 3;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_t;

    // Sum of 2^log2n samples of din_w bits needs exactly log2n extra bits.
    function automatic int acc_width(input int din_w, input int log2n);
        return din_w + log2n;
    endfunction

endpackage

// File: rtl/acc_out_slot.sv
// Single-entry valid/ready holding register: load writes when empty or draining this cycle.
// Zero latency load->valid at the edge; a load against a stalled full slot is dropped and flagged by drop.
module acc_out_slot #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         drop
);

    logic         valid_q;
    logic [W-1:0] dout_q;
    logic         can_load;

    assign can_load = !valid_q || ready;
    // Combinational so the parent can register overrun on the same edge as the drop.
    assign drop     = load && !can_load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else if (load && can_load) begin
            valid_q <= 1'b1;
            dout_q  <= data;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign dout  = dout_q;

endmodule

// File: rtl/mac_accum_ls.sv
// Accumulates blocks of 2^LOG2N unsigned samples; result valid at the edge taking the last sample.
// Input has no back-pressure; a completion against a stalled output slot is dropped and sets sticky overrun.
module mac_accum_ls
    import mac_ls_pkg::*;
#(
    parameter int DIN_W = MAC_DIN_W,
    parameter int LOG2N = MAC_LOG2N,
    localparam int ACC_W = acc_width(DIN_W, LOG2N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din_en,
    input  logic [DIN_W-1:0] din,
    input  logic             clr,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [ACC_W-1:0] dout_sum,
    output logic [DIN_W-1:0] dout_avg,
    output logic             overrun,
    output logic             busy
);

    acc_state_t       state_q;
    logic [LOG2N-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             busy_q;
    logic             overrun_q;

    logic [ACC_W-1:0] din_ext;
    logic [ACC_W-1:0] res_d;
    logic             take;
    logic             last;
    logic             complete;
    logic             drop;

    assign din_ext  = {{LOG2N{1'b0}}, din};
    assign res_d    = acc_q + din_ext;
    // clr discards a same-cycle sample, so it can never coincide with a completion.
    assign take     = din_en && !clr;
    assign last     = (cnt_q == {LOG2N{1'b1}});
    assign complete = take && (state_q == ACC) && last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (din_en) begin
            case (state_q)
                IDLE: begin
                    acc_q   <= din_ext;
                    cnt_q   <= LOG2N'(1);
                    busy_q  <= 1'b1;
                    state_q <= ACC;
                end
                ACC: begin
                    if (last) begin
                        // acc is left as is; the next block's first sample reloads it.
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q  <= res_d;
                        cnt_q  <= cnt_q + LOG2N'(1);
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q <= 1'b0;
        end else if (clr) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    acc_out_slot #(
        .W(ACC_W)
    ) u_slot (
        .clk   (clk),
        .rstn  (rstn),
        .load  (complete),
        .data  (res_d),
        .ready (dout_ready),
        .valid (dout_valid),
        .dout  (dout_sum),
        .drop  (drop)
    );

    assign dout_avg = dout_sum[ACC_W-1:LOG2N];
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule
